des_cbc_sequencer: RTL and testbench
====================================

Name: des_cbc_sequencer

Overview:
- Block-mode front end that sits directly upstream of Control_State_Machine, the iterative DES core.
- Accepts 64-bit blocks on a valid/ready stream and applies CBC chaining, or ECB when cbc_en=0.
- Drives the core's start/key/input_text pins and waits for the matching done. It returns the chained result on a valid/ready output stream.
- Holds the IV/chain register between blocks so a message can be streamed block by block.

Parameters:
TIMEOUT_CYCLES, 64, maximum cycles spent in WAIT_CORE before the operation is aborted
CNT_W, 7, width of the wait counter; must hold TIMEOUT_CYCLES

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
mode_decrypt  input  1  0=encrypt, 1=decrypt; sampled on input handshake
cbc_en  input  1  1=CBC, 0=ECB; sampled on input handshake
key  input  64  DES key; sampled on input handshake
iv  input  64  initialisation vector
load_iv  input  1  chain_reg<=iv; honoured only in IDLE
in_valid  input  1  input block valid
in_ready  output  1  block accepted when in_valid&&in_ready
in_data  input  64  plaintext or ciphertext block
out_valid  output  1  result valid
out_ready  input  1  consumer ready
out_data  output  64  result block
busy  output  1  state != IDLE
timeout_err  output  1  sticky; set on core timeout, cleared by reset or load_iv
core_start_encrypt  output  1  one-cycle pulse to core
core_start_decrypt  output  1  one-cycle pulse to core
core_key  output  64  registered key to core
core_input_text  output  64  registered block to core
core_done_encrypt  input  1  from core
core_done_decrypt  input  1  from core
core_output_text  input  64  from core

Behaviour:
- Reset values: state IDLE; chain_reg, out_data, core_key and core_input_text all 0. core_start_* 0, out_valid 0, timeout_err 0, busy 0.
- in_ready = (state==IDLE), combinational.
- FSM states: IDLE, ISSUE, WAIT_CORE, OUTPUT.
- IDLE:
  - load_iv loads chain_reg<=iv.
  - On handshake, latch in_data into blk_reg, along with mode_decrypt, cbc_en and key.
  - core_input_text <= (cbc_en && !mode_decrypt) ? in_data^chain_reg : in_data.
  - Transition to ISSUE.
  - If load_iv and the handshake occur in the same cycle, the IV is loaded first and the XOR uses iv.
- ISSUE: exactly one cycle.
  - core_start_encrypt or core_start_decrypt is high for that cycle, per the latched mode.
  - Wait counter cleared. Go to WAIT_CORE.
- WAIT_CORE:
  - Counter increments every cycle.
  - Only the done matching the latched mode is honoured; the other is ignored.
  - done is ignored while counter<2, which guards against a stale done level from the prior operation.
  - On done:
    - out_data <= (cbc_en && mode_decrypt) ? core_output_text^chain_reg : core_output_text.
    - chain_reg <= mode_decrypt ? blk_reg : core_output_text. This update happens only when cbc_en.
    - out_valid<=1; go to OUTPUT.
  - On counter==TIMEOUT_CYCLES without done: timeout_err<=1, chain_reg unchanged, no output, return to IDLE.
- OUTPUT:
  - out_valid and out_data are held stable until out_ready.
  - On handshake, out_valid<=0 and the FSM returns to IDLE. in_ready rises the next cycle.
  - Minimum one bubble cycle between blocks.
- Latency:
  - Input handshake at edge N; start pulse during cycle N+1.
  - out_valid asserts one cycle after the core's done is sampled.
- Stimulus held or changed on mode_decrypt, cbc_en and key after acceptance has no effect on an in-flight block.
- Asynchronous reset mid-operation:
  - All registers return to reset values immediately, including a cleared chain_reg. Any start pulse drops.
  - The core is reset by the same rst.
- No arithmetic beyond 64-bit XOR. The counter saturates and never wraps.

Test Plan:
1. ECB encrypt: key=133457799BBCDFF1, in_data=0123456789ABCDEF, cbc_en=0 -> one start_encrypt pulse; out_data=85E813540F0AB405; chain_reg stays 0.
2. CBC encrypt: load_iv with iv=0123456789ABCDEF, in_data=0000000000000000, same key -> core_input_text=0123456789ABCDEF; out_data=85E813540F0AB405; chain_reg=85E813540F0AB405.
3. CBC decrypt: load_iv with iv=0123456789ABCDEF, in_data=85E813540F0AB405, mode_decrypt=1 -> start_decrypt pulse; out_data=0000000000000000; chain_reg=85E813540F0AB405.
4. Backpressure: hold out_ready=0 for 10 cycles after out_valid -> out_data stable, in_ready=0, no second start pulse. After out_ready=1, in_ready=1 the following cycle.
5. Timeout: stub core never asserts done, TIMEOUT_CYCLES=64 -> timeout_err=1 after 64 WAIT_CORE cycles; state IDLE; out_valid never asserted. A subsequent load_iv clears timeout_err.
6. Reset mid-op: assert rst during WAIT_CORE of scenario 2 -> out_valid=0, busy=0, chain_reg=0 immediately. After release, scenario 1 reproduces 85E813540F0AB405.

Source files
------------

// File: rtl/des_cbc_sequencer.sv
// CBC/ECB block sequencer for the iterative DES core: latches one block, issues it
// to the core, waits for the matching done and returns the chained result.
module des_cbc_sequencer #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mode_decrypt,
    input  logic        cbc_en,
    input  logic [63:0] key,
    input  logic [63:0] iv,
    input  logic        load_iv,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_data,
    output logic        busy,
    output logic        timeout_err,
    output logic        core_start_encrypt,
    output logic        core_start_decrypt,
    output logic [63:0] core_key,
    output logic [63:0] core_input_text,
    input  logic        core_done_encrypt,
    input  logic        core_done_decrypt,
    input  logic [63:0] core_output_text,
    output logic [1:0]  dbg_state,
    output logic [63:0] dbg_chain
);
    // Valid/ready: a transfer happens on a rising edge where valid and ready are both high;
    // the producer holds valid and data stable until then, ready may be driven freely.
    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] ISSUE     = 2'd1;
    localparam logic [1:0] WAIT_CORE = 2'd2;
    localparam logic [1:0] OUTPUT    = 2'd3;

    // Counter reads 0 on the first WAIT_CORE cycle, so this is the last permitted cycle.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_MIN  = CNT_W'(2);

    logic [1:0]       state;
    logic [63:0]      chain_reg;
    logic [63:0]      blk_reg;
    logic [63:0]      chain_src;
    logic             mode_r;
    logic             cbc_r;
    logic [CNT_W-1:0] cnt;
    logic             done_hit;

    assign in_ready  = (state == IDLE);
    assign busy      = (state != IDLE);
    assign dbg_state = state;
    assign dbg_chain = chain_reg;

    // A same-cycle IV load takes effect before the XOR of the accepted block.
    assign chain_src = load_iv ? iv : chain_reg;

    // The first two WAIT_CORE cycles may still see the previous operation's done level.
    assign done_hit = (mode_r ? core_done_decrypt : core_done_encrypt) && (cnt >= CNT_MIN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state              <= IDLE;
            chain_reg          <= '0;
            blk_reg            <= '0;
            mode_r             <= 1'b0;
            cbc_r              <= 1'b0;
            cnt                <= '0;
            out_valid          <= 1'b0;
            out_data           <= '0;
            timeout_err        <= 1'b0;
            core_start_encrypt <= 1'b0;
            core_start_decrypt <= 1'b0;
            core_key           <= '0;
            core_input_text    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (load_iv) begin
                        chain_reg   <= iv;
                        timeout_err <= 1'b0;
                    end
                    if (in_valid) begin
                        blk_reg            <= in_data;
                        mode_r             <= mode_decrypt;
                        cbc_r              <= cbc_en;
                        core_key           <= key;
                        core_input_text    <= (cbc_en && !mode_decrypt) ? (in_data ^ chain_src) : in_data;
                        core_start_encrypt <= !mode_decrypt;
                        core_start_decrypt <= mode_decrypt;
                        state              <= ISSUE;
                    end
                end
                ISSUE: begin
                    core_start_encrypt <= 1'b0;
                    core_start_decrypt <= 1'b0;
                    cnt                <= '0;
                    state              <= WAIT_CORE;
                end
                WAIT_CORE: begin
                    if (done_hit) begin
                        out_data  <= (cbc_r && mode_r) ? (core_output_text ^ chain_reg) : core_output_text;
                        if (cbc_r) begin
                            chain_reg <= mode_r ? blk_reg : core_output_text;
                        end
                        out_valid <= 1'b1;
                        state     <= OUTPUT;
                    end else if (cnt == CNT_LAST) begin
                        timeout_err <= 1'b1;
                        state       <= IDLE;
                    end else if (cnt != CNT_MAX) begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                OUTPUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_des_cbc_sequencer.sv
// Bench for des_cbc_sequencer: stub DES core, CBC reference model and output scoreboard.
module tb_des_cbc_sequencer;
    localparam logic [63:0] K0  = 64'h133457799BBCDFF1;
    localparam logic [63:0] P0  = 64'h0123456789ABCDEF;
    localparam logic [63:0] C0  = 64'h85E813540F0AB405;
    localparam logic [63:0] MSK = 64'h5A3C96E10F7B24D8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mode_decrypt = 1'b0;
    logic        cbc_en = 1'b0;
    logic [63:0] key = '0;
    logic [63:0] iv = '0;
    logic        load_iv = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] out_data;
    logic        busy;
    logic        timeout_err;
    logic        core_start_encrypt;
    logic        core_start_decrypt;
    logic [63:0] core_key;
    logic [63:0] core_input_text;
    logic        core_done_encrypt = 1'b0;
    logic        core_done_decrypt = 1'b0;
    logic [63:0] core_output_text = '0;
    logic [1:0]  dbg_state;
    logic [63:0] dbg_chain;

    int          n_vec = 0;
    int          n_err = 0;
    int          start_cnt = 0;
    logic        stub_alive = 1'b1;
    logic        force_rdy = 1'b0;
    logic        rdy_val = 1'b0;
    logic [63:0] m_chain = '0;
    logic [63:0] exp_q[$];
    logic [63:0] got_q[$];
    logic [128:0] exp_in_q[$];

    always #5 clk = ~clk;

    des_cbc_sequencer #(.TIMEOUT_CYCLES(64), .CNT_W(7)) dut (
        .clk(clk), .rst(rst), .mode_decrypt(mode_decrypt), .cbc_en(cbc_en), .key(key),
        .iv(iv), .load_iv(load_iv), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy), .timeout_err(timeout_err), .core_start_encrypt(core_start_encrypt),
        .core_start_decrypt(core_start_decrypt), .core_key(core_key),
        .core_input_text(core_input_text), .core_done_encrypt(core_done_encrypt),
        .core_done_decrypt(core_done_decrypt), .core_output_text(core_output_text),
        .dbg_state(dbg_state), .dbg_chain(dbg_chain)
    );

    // Stand-in block cipher: invertible per key, with the known DES vector pinned.
    function automatic logic [63:0] core_enc(input logic [63:0] k, input logic [63:0] x);
        if (k == K0 && x == P0) return C0;
        return {x[55:0], x[63:56]} ^ k ^ MSK;
    endfunction

    function automatic logic [63:0] core_dec(input logic [63:0] k, input logic [63:0] y);
        logic [63:0] t;
        if (k == K0 && y == C0) return P0;
        t = y ^ k ^ MSK;
        return {t[7:0], t[63:8]};
    endfunction

    function automatic void check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rdy_driver();
        forever begin
            @(posedge clk);
            #1;
            out_ready = force_rdy ? rdy_val : ($urandom_range(0, 3) != 0);
        end
    endtask

    // Stub core: holds the previous done level for two wait cycles, pulses the
    // non-matching done with garbage, then raises the matching done with the result.
    task automatic core_stub();
        logic [63:0]  res;
        logic [128:0] e;
        logic         dec;
        int           dly;
        forever begin
            @(negedge clk);
            if (!rst && (core_start_encrypt || core_start_decrypt)) begin
                dec = core_start_decrypt;
                if (exp_in_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_start: got start with input %h, expected none", core_input_text);
                end else begin
                    e = exp_in_q.pop_front();
                    check("core_mode", 64'(dec), 64'(e[128]));
                    check("core_key", core_key, e[127:64]);
                    check("core_in", core_input_text, e[63:0]);
                end
                res = dec ? core_dec(core_key, core_input_text) : core_enc(core_key, core_input_text);
                dly = $urandom_range(0, 3);
                repeat (3) @(negedge clk);
                core_done_encrypt = 1'b0;
                core_done_decrypt = 1'b0;
                if (stub_alive) begin
                    repeat (dly) @(negedge clk);
                    core_output_text = ~res;
                    if (dec) core_done_encrypt = 1'b1;
                    else core_done_decrypt = 1'b1;
                    @(negedge clk);
                    core_done_encrypt = !dec;
                    core_done_decrypt = dec;
                    core_output_text  = res;
                end
            end
        end
    endtask

    task automatic monitor();
        logic        hold;
        logic [63:0] held;
        hold = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                hold = 1'b0;
                continue;
            end
            if (core_start_encrypt || core_start_decrypt) start_cnt++;
            if (hold && out_valid) check("hold_stable", out_data, held);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_out: got %h, expected no output", out_data);
                end else begin
                    check("out_data", out_data, exp_q.pop_front());
                end
                got_q.push_back(out_data);
            end
            hold = out_valid && !out_ready;
            held = out_data;
        end
    endtask

    task automatic wait_ready();
        int t;
        t = 0;
        while (!in_ready && t < 400) begin
            tick();
            t++;
        end
    endtask

    // Reference model: CBC chaining applied at block level around the stub cipher.
    task automatic send(input logic dec, input logic cbc, input logic [63:0] k, input logic [63:0] d,
                        input logic ld, input logic [63:0] ivv, input logic want_out);
        logic [63:0] x, y, o;
        wait_ready();
        if (!in_ready) begin
            check("in_ready_wait", 64'(in_ready), 64'd1);
            return;
        end
        mode_decrypt = dec;
        cbc_en       = cbc;
        key          = k;
        in_data      = d;
        load_iv      = ld;
        iv           = ivv;
        in_valid     = 1'b1;
        if (ld) m_chain = ivv;
        if (!dec) begin
            x = cbc ? (d ^ m_chain) : d;
            y = core_enc(k, x);
            o = y;
        end else begin
            x = d;
            y = core_dec(k, x);
            o = cbc ? (y ^ m_chain) : y;
        end
        exp_in_q.push_back({dec, k, x});
        if (want_out) begin
            exp_q.push_back(o);
            if (cbc) m_chain = dec ? d : y;
        end
        tick();
        in_valid     = 1'b0;
        load_iv      = 1'b0;
        mode_decrypt = 1'($urandom);
        cbc_en       = 1'($urandom);
        key          = {$urandom, $urandom};
        in_data      = {$urandom, $urandom};
        check("start_enc", 64'(core_start_encrypt), 64'(!dec));
        check("start_dec", 64'(core_start_decrypt), 64'(dec));
    endtask

    task automatic do_load_iv(input logic [63:0] v);
        wait_ready();
        load_iv = 1'b1;
        iv      = v;
        tick();
        load_iv = 1'b0;
        m_chain = v;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while ((exp_q.size() != 0 || !in_ready) && t < 1000) begin
            tick();
            t++;
        end
        check("idle_wait", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        logic [63:0] d, k, r_iv;
        logic [63:0] pt[4];
        logic [63:0] ct[4];
        logic        ov;
        int          s0, t;

        fork
            rdy_driver();
            core_stub();
            monitor();
            begin
                #2000000;
                $display("FAIL watchdog: got no completion, expected finish within time limit");
                $fatal(1, "watchdog expired");
            end
        join_none

        @(posedge clk);
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_timeout", 64'(timeout_err), 64'd0);
        check("rst_starts", 64'({core_start_encrypt, core_start_decrypt}), 64'd0);
        check("rst_out_data", out_data, 64'd0);
        check("rst_core_key", core_key, 64'd0);
        check("rst_core_in", core_input_text, 64'd0);
        check("rst_chain", dbg_chain, 64'd0);
        repeat (2) tick();
        rst = 1'b0;
        tick();

        // ECB encrypt of the known vector
        got_q.delete();
        s0 = start_cnt;
        send(1'b0, 1'b0, K0, P0, 1'b0, 64'd0, 1'b1);
        wait_idle();
        check("ecb_out", got_q[$], C0);
        check("ecb_chain", dbg_chain, 64'd0);
        check("ecb_starts", 64'(start_cnt - s0), 64'd1);

        // CBC encrypt with IV loaded in the same cycle as the block
        send(1'b0, 1'b1, K0, 64'd0, 1'b1, P0, 1'b1);
        check("cbc_enc_core_in", core_input_text, P0);
        wait_idle();
        check("cbc_enc_out", got_q[$], C0);
        check("cbc_enc_chain", dbg_chain, C0);

        // CBC decrypt back to zero
        do_load_iv(P0);
        send(1'b1, 1'b1, K0, C0, 1'b0, 64'd0, 1'b1);
        wait_idle();
        check("cbc_dec_out", got_q[$], 64'd0);
        check("cbc_dec_chain", dbg_chain, C0);

        // Backpressure: result held, no new input, IV load ignored while busy
        force_rdy = 1'b1;
        rdy_val   = 1'b0;
        tick();
        send(1'b0, 1'b0, {$urandom, $urandom}, {$urandom, $urandom}, 1'b0, 64'd0, 1'b1);
        t = 0;
        while (!out_valid && t < 50) begin
            tick();
            t++;
        end
        check("bp_valid_rise", 64'(out_valid), 64'd1);
        s0 = start_cnt;
        d  = out_data;
        load_iv = 1'b1;
        iv      = {$urandom, $urandom};
        for (int i = 0; i < 10; i++) begin
            tick();
            load_iv = 1'b0;
            check("bp_hold", out_data, d);
            check("bp_in_ready", 64'(in_ready), 64'd0);
        end
        check("bp_no_start", 64'(start_cnt - s0), 64'd0);
        rdy_val = 1'b1;
        t = 0;
        while (out_valid && t < 10) begin
            tick();
            t++;
        end
        check("bp_release", 64'(out_valid), 64'd0);
        check("bp_ready_after", 64'(in_ready), 64'd1);
        check("bp_chain", dbg_chain, m_chain);
        force_rdy = 1'b0;
        wait_idle();

        // Randomised mixed traffic
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 9) == 0) do_load_iv({$urandom, $urandom});
            case ($urandom_range(0, 2))
                0: k = K0;
                1: k = 64'h0E329232EA6D0D73;
                default: k = {$urandom, $urandom};
            endcase
            send(1'($urandom), 1'($urandom), k, {$urandom, $urandom},
                 ($urandom_range(0, 7) == 0), {$urandom, $urandom}, 1'b1);
        end
        wait_idle();
        check("rand_chain", dbg_chain, m_chain);

        // CBC round trip: decrypting the ciphertext stream recovers the message
        k    = {$urandom, $urandom};
        r_iv = {$urandom, $urandom};
        do_load_iv(r_iv);
        got_q.delete();
        for (int i = 0; i < 4; i++) begin
            pt[i] = {$urandom, $urandom};
            send(1'b0, 1'b1, k, pt[i], 1'b0, 64'd0, 1'b1);
        end
        wait_idle();
        check("rt_enc_count", 64'(got_q.size()), 64'd4);
        for (int i = 0; i < 4; i++) ct[i] = (got_q.size() != 0) ? got_q.pop_front() : 64'd0;
        do_load_iv(r_iv);
        for (int i = 0; i < 4; i++) send(1'b1, 1'b1, k, ct[i], 1'b0, 64'd0, 1'b1);
        wait_idle();
        check("rt_dec_count", 64'(got_q.size()), 64'd4);
        for (int i = 0; i < 4; i++) check("rt_plain", (got_q.size() != 0) ? got_q.pop_front() : 64'd0, pt[i]);

        // Core never answers
        stub_alive = 1'b0;
        send(1'b0, 1'b0, {$urandom, $urandom}, {$urandom, $urandom}, 1'b0, 64'd0, 1'b0);
        ov = 1'b0;
        for (int i = 0; i < 60; i++) begin
            tick();
            ov = ov | out_valid;
        end
        check("to_early", 64'(timeout_err), 64'd0);
        t = 0;
        while (!timeout_err && t < 30) begin
            tick();
            ov = ov | out_valid;
            t++;
        end
        check("to_set", 64'(timeout_err), 64'd1);
        check("to_idle", 64'(busy), 64'd0);
        check("to_no_out", 64'(ov), 64'd0);
        check("to_chain", dbg_chain, m_chain);
        stub_alive = 1'b1;
        do_load_iv({$urandom, $urandom});
        check("to_clear", 64'(timeout_err), 64'd0);

        // Reset while the core is working
        send(1'b0, 1'b1, K0, 64'd0, 1'b1, P0, 1'b1);
        tick();
        rst = 1'b1;
        #1;
        check("mid_rst_valid", 64'(out_valid), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_chain", dbg_chain, 64'd0);
        check("mid_rst_start", 64'({core_start_encrypt, core_start_decrypt}), 64'd0);
        exp_q.delete();
        m_chain = '0;
        repeat (3) tick();
        rst = 1'b0;
        repeat (12) tick();
        got_q.delete();
        send(1'b0, 1'b0, K0, P0, 1'b0, 64'd0, 1'b1);
        wait_idle();
        check("post_rst_out", got_q[$], C0);
        check("post_rst_chain", dbg_chain, 64'd0);

        repeat (5) tick();
        check("final_in_q", 64'(exp_in_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
